apb_master_arb: RTL and testbench

Shares the single APB slave port of the peripheral APB node between `NB_REQ` simple request/grant masters, such as the core data port, the debug unit and the DMA. It uses round-robin arbitration. Each grant is turned into a legal APB SETUP/ACCESS sequence. The slave response is returned to the winning requester. A PREADY timeout guarantees that a hung peripheral cannot lock the bus.

---
 rtl/apb_master_arb_pkg.sv | 16 +
 rtl/apb_master_arb_if.sv | 40 ++++
 rtl/apb_master_arb_rr_arbiter.sv | 45 ++++
 rtl/apb_master_arb.sv | 119 +++++++++++
 tb/tb_apb_master_arb.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_master_arb_pkg.sv
// Shared types and helpers for the APB master arbiter: FSM state encoding
// and the timeout counter width.
package apb_master_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t SETUP  = 2'd1;
  localparam state_t ACCESS = 2'd2;

  // Width needed to count up to TIMEOUT; never narrower than one bit.
  function automatic int unsigned to_w(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/apb_master_arb_if.sv
// Requester-side and APB-side signals of the arbiter, bundled as one interface.
// master is the arbiter's view; slave is the view of requesters plus APB slave.
interface apb_master_arb_if #(
  parameter int unsigned NB_REQ         = 4,
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32
) ();

  logic [NB_REQ-1:0]                     req_i;
  logic [NB_REQ-1:0][APB_ADDR_WIDTH-1:0] addr_i;
  logic [NB_REQ-1:0]                     we_i;
  logic [NB_REQ-1:0][APB_DATA_WIDTH-1:0] wdata_i;
  logic [NB_REQ-1:0]                     gnt_o;
  logic [NB_REQ-1:0]                     rvalid_o;
  logic [APB_DATA_WIDTH-1:0]             rdata_o;
  logic                                  err_o;
  logic                                  busy_o;

  logic                                  psel_o;
  logic                                  penable_o;
  logic                                  pwrite_o;
  logic [APB_ADDR_WIDTH-1:0]             paddr_o;
  logic [APB_DATA_WIDTH-1:0]             pwdata_o;
  logic [APB_DATA_WIDTH-1:0]             prdata_i;
  logic                                  pready_i;
  logic                                  pslverr_i;

  modport master (
    input  req_i, addr_i, we_i, wdata_i, prdata_i, pready_i, pslverr_i,
    output gnt_o, rvalid_o, rdata_o, err_o, busy_o,
           psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
  );

  modport slave (
    output req_i, addr_i, we_i, wdata_i, prdata_i, pready_i, pslverr_i,
    input  gnt_o, rvalid_o, rdata_o, err_o, busy_o,
           psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
  );

endinterface

// File: rtl/apb_master_arb_rr_arbiter.sv
// Round-robin picker: combinational one-hot winner searched from ptr upward,
// wrapping at N-1; ptr moves past the winner only when advance is high.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] ptr;
  logic [IW:0]   pos;

  // First requester at or after ptr, modulo N.
  always_comb begin
    any = 1'b0;
    idx = '0;
    pos = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (IW+1)'(k);
      if (pos >= (IW+1)'(N)) begin
        pos = pos - (IW+1)'(N);
      end
      if (!any && req[pos[IW-1:0]]) begin
        any = 1'b1;
        idx = pos[IW-1:0];
      end
    end
    gnt = any ? (N'(1) << idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
    end
  end

endmodule

// File: rtl/apb_master_arb.sv
// Shares one APB master port between NB_REQ request/grant masters: round-robin
// pick, SETUP/ACCESS sequencing, response return and PREADY timeout.
module apb_master_arb
  import apb_master_arb_pkg::*;
#(
  parameter int unsigned NB_REQ         = 4,
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT        = 255
) (
  input  logic            clk,
  input  logic            rst,
  apb_master_arb_if.master bus
);

  localparam int unsigned IW = $clog2(NB_REQ);
  localparam int unsigned TW = to_w(TIMEOUT);

  state_t            state;
  state_t            state_n;
  logic              start_c;
  logic              done_c;
  logic              timed_out_c;
  logic [NB_REQ-1:0] win_gnt;
  logic [IW-1:0]     win_idx;
  logic              win_any;
  logic [IW-1:0]     idx;
  logic [TW-1:0]     cnt;

  rr_arbiter #(.N(NB_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.req_i),
    .advance (start_c),
    .gnt     (win_gnt),
    .idx     (win_idx),
    .any     (win_any)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state plus the start/finish strobes that steer the registers below.
  always_comb begin
    state_n     = state;
    start_c     = 1'b0;
    done_c      = 1'b0;
    timed_out_c = 1'b0;
    case (state)
      IDLE: begin
        if (win_any) begin
          start_c = 1'b1;
          state_n = SETUP;
        end
      end
      SETUP: state_n = ACCESS;
      ACCESS: begin
        if (bus.pready_i) begin
          done_c  = 1'b1;
          state_n = IDLE;
        end else if (TIMEOUT != 0 && cnt == TW'(TIMEOUT)) begin
          done_c      = 1'b1;
          timed_out_c = 1'b1;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // APB address/control/data double as the request latch and read 0 when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx           <= '0;
      cnt           <= '0;
      bus.gnt_o     <= '0;
      bus.rvalid_o  <= '0;
      bus.rdata_o   <= '0;
      bus.err_o     <= 1'b0;
      bus.busy_o    <= 1'b0;
      bus.psel_o    <= 1'b0;
      bus.penable_o <= 1'b0;
      bus.pwrite_o  <= 1'b0;
      bus.paddr_o   <= '0;
      bus.pwdata_o  <= '0;
    end else begin
      bus.gnt_o     <= start_c ? win_gnt : '0;
      bus.busy_o    <= (state_n != IDLE);
      bus.psel_o    <= (state_n != IDLE);
      bus.penable_o <= (state_n == ACCESS);

      if (start_c) begin
        idx          <= win_idx;
        bus.paddr_o  <= bus.addr_i[win_idx];
        bus.pwrite_o <= bus.we_i[win_idx];
        bus.pwdata_o <= bus.wdata_i[win_idx];
      end else if (done_c) begin
        bus.paddr_o  <= '0;
        bus.pwrite_o <= 1'b0;
        bus.pwdata_o <= '0;
      end

      // Cleared outside ACCESS so every transfer starts counting from zero.
      if (state != ACCESS) begin
        cnt <= '0;
      end else if (cnt != {TW{1'b1}}) begin
        cnt <= cnt + TW'(1);
      end

      bus.rvalid_o <= done_c ? (NB_REQ'(1) << idx) : '0;
      bus.rdata_o  <= (done_c && !timed_out_c && !bus.pwrite_o && !bus.pslverr_i)
                      ? bus.prdata_i : '0;
      bus.err_o    <= done_c && (timed_out_c || bus.pslverr_i);
    end
  end

endmodule

// File: tb/tb_apb_master_arb.sv
// Scoreboard bench for apb_master_arb: stimulus queues expected grants and
// responses, a monitor pops and compares them as the DUT presents them.
module tb_apb_master_arb;

  localparam int unsigned NB = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  typedef struct {
    int          idx;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } gnt_exp_t;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
  } rsp_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  gnt_exp_t    exp_gnt[$];
  rsp_exp_t    exp_rsp[$];
  int          gnt_cyc[$];
  int          checks    = 0;
  int          failures  = 0;
  int          cyc       = 0;
  int          gnt_seen  = 0;
  logic        hold      = 1'b0;
  int          slv_waits = 0;
  logic        slv_stuck = 1'b0;
  logic        slv_err   = 1'b0;
  logic [31:0] slv_rdata = 32'h0;

  always #5 clk = ~clk;

  apb_master_arb_if #(.NB_REQ(NB), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW)) bus ();

  apb_master_arb #(
    .NB_REQ(NB), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Requesters drop req the cycle after their grant unless hold is set.
  task automatic tick();
    @(negedge clk);
    if (!hold) bus.req_i = bus.req_i & ~bus.gnt_o;
  endtask

  task automatic issue(input int i, input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [31:0] erd, input logic eerr, input logic has_rsp);
    gnt_exp_t g;
    rsp_exp_t r;
    bus.req_i[i]   = 1'b1;
    bus.addr_i[i]  = a;
    bus.we_i[i]    = w;
    bus.wdata_i[i] = d;
    g.idx = i; g.addr = a; g.we = w; g.wdata = d;
    exp_gnt.push_back(g);
    if (has_rsp) begin
      r.idx = i; r.rdata = erd; r.err = eerr;
      exp_rsp.push_back(r);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_rsp.size() != 0 || bus.busy_o) && n < 100) begin
      tick();
      n++;
    end
    chk({name, "_idle_bound"}, 64'(n >= 100), 64'd0);
    tick();
  endtask

  task automatic count_access(output int n);
    int w;
    w = 0;
    n = 0;
    while (!(bus.psel_o && bus.penable_o) && w < 20) begin
      tick();
      w++;
    end
    while (bus.psel_o && bus.penable_o && n < 50) begin
      n++;
      tick();
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"},     64'(bus.gnt_o),     64'd0);
    chk({tag, "_rvalid"},  64'(bus.rvalid_o),  64'd0);
    chk({tag, "_rdata"},   64'(bus.rdata_o),   64'd0);
    chk({tag, "_err"},     64'(bus.err_o),     64'd0);
    chk({tag, "_busy"},    64'(bus.busy_o),    64'd0);
    chk({tag, "_psel"},    64'(bus.psel_o),    64'd0);
    chk({tag, "_penable"}, 64'(bus.penable_o), 64'd0);
    chk({tag, "_pwrite"},  64'(bus.pwrite_o),  64'd0);
    chk({tag, "_paddr"},   64'(bus.paddr_o),   64'd0);
    chk({tag, "_pwdata"},  64'(bus.pwdata_o),  64'd0);
  endtask

  // Scoreboard monitor: every grant and completion must match the queue head.
  task automatic monitor();
    gnt_exp_t g;
    rsp_exp_t r;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.gnt_o != '0) begin
        gnt_seen++;
        gnt_cyc.push_back(cyc);
        if (exp_gnt.size() == 0) begin
          chk("unexpected_gnt", 64'(bus.gnt_o), 64'd0);
        end else begin
          g = exp_gnt.pop_front();
          chk("gnt",          64'(bus.gnt_o),     64'(NB'(1) << g.idx));
          chk("setup_psel",   64'(bus.psel_o),    64'd1);
          chk("setup_pen",    64'(bus.penable_o), 64'd0);
          chk("setup_paddr",  64'(bus.paddr_o),   64'(g.addr));
          chk("setup_pwrite", 64'(bus.pwrite_o),  64'(g.we));
          chk("setup_pwdata", 64'(bus.pwdata_o),  64'(g.wdata));
        end
      end
      if (bus.rvalid_o != '0) begin
        if (exp_rsp.size() == 0) begin
          chk("unexpected_rvalid", 64'(bus.rvalid_o), 64'd0);
        end else begin
          r = exp_rsp.pop_front();
          chk("rvalid", 64'(bus.rvalid_o), 64'(NB'(1) << r.idx));
          chk("rdata",  64'(bus.rdata_o),  64'(r.rdata));
          chk("err",    64'(bus.err_o),    64'(r.err));
        end
      end
    end
  endtask

  // APB slave: pready after slv_waits ACCESS cycles, never when stuck.
  task automatic slave();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.psel_o && bus.penable_o) begin
        bus.pready_i  = !slv_stuck && (n == slv_waits);
        bus.prdata_i  = slv_rdata;
        bus.pslverr_i = slv_err;
        n++;
      end else begin
        n = 0;
        bus.pready_i  = 1'b0;
        bus.prdata_i  = '0;
        bus.pslverr_i = 1'b0;
      end
    end
  endtask

  task automatic run_tests();
    int n;
    int base;
    int c0;

    repeat (2) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // All four held high from ptr=0: grants 0,1,2,3,0 three cycles apart.
    slv_waits = 0;
    slv_rdata = 32'h1111_2222;
    hold      = 1'b1;
    issue(0, 32'h1A10_0000, 1'b0, 32'h0,   32'h1111_2222, 1'b0, 1'b1);
    issue(1, 32'h1A10_0100, 1'b1, 32'h101, 32'h0,         1'b0, 1'b1);
    issue(2, 32'h1A10_0200, 1'b0, 32'h0,   32'h1111_2222, 1'b0, 1'b1);
    issue(3, 32'h1A10_0300, 1'b1, 32'h303, 32'h0,         1'b0, 1'b1);
    issue(0, 32'h1A10_0000, 1'b0, 32'h0,   32'h1111_2222, 1'b0, 1'b1);
    base = gnt_seen;
    c0   = gnt_cyc.size();
    n    = 0;
    while (gnt_seen < base + 5 && n < 40) begin
      tick();
      n++;
    end
    chk("rr_grant_count", 64'(gnt_seen - base), 64'd5);
    bus.req_i = '0;
    hold      = 1'b0;
    wait_idle("rr");
    for (int k = 1; k < 5; k++) begin
      if (gnt_cyc.size() > c0 + k) chk("rr_spacing", 64'(gnt_cyc[c0+k] - gnt_cyc[c0+k-1]), 64'd3);
    end

    // Single read, minimum latency; ptr is 1 so this also covers a lone requester.
    slv_rdata = 32'hCAFE_F00D;
    issue(0, 32'h1A10_0008, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1);
    tick();
    chk("rd_c1_gnt",  64'(bus.gnt_o),     64'h1);
    chk("rd_c1_psel", 64'(bus.psel_o),    64'd1);
    chk("rd_c1_pen",  64'(bus.penable_o), 64'd0);
    tick();
    chk("rd_c2_psel", 64'(bus.psel_o),    64'd1);
    chk("rd_c2_pen",  64'(bus.penable_o), 64'd1);
    tick();
    chk("rd_c3_rvalid", 64'(bus.rvalid_o), 64'h1);
    chk("rd_c3_psel",   64'(bus.psel_o),   64'd0);
    wait_idle("rd");

    // Write with two wait states: controls stable through all ACCESS cycles.
    slv_waits = 2;
    slv_rdata = 32'hDEAD_BEEF;
    issue(2, 32'h1A10_1000, 1'b1, 32'h0000_00FF, 32'h0, 1'b0, 1'b1);
    n = 0;
    while (!bus.penable_o && n < 10) begin
      tick();
      n++;
    end
    n = 0;
    while (bus.penable_o && n < 10) begin
      chk("wr_pwrite", 64'(bus.pwrite_o), 64'd1);
      chk("wr_pwdata", 64'(bus.pwdata_o), 64'h0000_00FF);
      chk("wr_paddr",  64'(bus.paddr_o),  64'h1A10_1000);
      n++;
      tick();
    end
    chk("wr_access_cycles", 64'(n), 64'd3);
    wait_idle("wr");

    // Slave error on a write, then a clean read from the same requester.
    slv_waits = 0;
    slv_err   = 1'b1;
    issue(1, 32'h1A10_2000, 1'b1, 32'h1234, 32'h0, 1'b1, 1'b1);
    wait_idle("slverr");
    slv_err   = 1'b0;
    slv_rdata = 32'h600D_D00D;
    issue(1, 32'h1A10_2004, 1'b0, 32'h0, 32'h600D_D00D, 1'b0, 1'b1);
    wait_idle("after_err");

    // ptr=2 with req0 and req3 pending: 3 wins, 0 is kept and served next.
    slv_rdata = 32'h1357_9BDF;
    issue(3, 32'h1A10_5000, 1'b0, 32'h0, 32'h1357_9BDF, 1'b0, 1'b1);
    issue(0, 32'h1A10_5004, 1'b0, 32'h0, 32'h1357_9BDF, 1'b0, 1'b1);
    wait_idle("simul");

    // Stuck slave: TO+1 ACCESS cycles then an error completion.
    slv_stuck = 1'b1;
    issue(0, 32'h1A10_3000, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    count_access(n);
    chk("to_access_cycles", 64'(n), 64'(TO + 1));
    wait_idle("timeout");

    // pready on the very cycle the timeout would fire: normal completion.
    slv_stuck = 1'b0;
    slv_waits = 4;
    slv_rdata = 32'hA5A5_5A5A;
    issue(0, 32'h1A10_3004, 1'b0, 32'h0, 32'hA5A5_5A5A, 1'b0, 1'b1);
    count_access(n);
    chk("to_edge_access_cycles", 64'(n), 64'(TO + 1));
    wait_idle("to_edge");

    // Reset during ACCESS: no completion, outputs cleared, ptr back to 0.
    slv_stuck = 1'b1;
    issue(1, 32'h1A10_4000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    chk("midrst_in_access", 64'(bus.penable_o), 64'd1);
    rst = 1'b1;
    tick();
    check_all_zero("midrst");
    rst = 1'b0;
    repeat (3) tick();
    slv_stuck = 1'b0;
    slv_waits = 0;
    slv_rdata = 32'h2468_ACE0;
    issue(1, 32'h1A10_6000, 1'b0, 32'h0, 32'h2468_ACE0, 1'b0, 1'b1);
    issue(3, 32'h1A10_6004, 1'b0, 32'h0, 32'h2468_ACE0, 1'b0, 1'b1);
    wait_idle("post_rst");
    chk("final_gnt_queue", 64'(exp_gnt.size()), 64'd0);
  endtask

  initial begin
    bus.req_i     = '0;
    bus.addr_i    = '0;
    bus.we_i      = '0;
    bus.wdata_i   = '0;
    bus.prdata_i  = '0;
    bus.pready_i  = 1'b0;
    bus.pslverr_i = 1'b0;
    fork
      monitor();
      slave();
      run_tests();
      begin
        repeat (20000) @(posedge clk);
        checks++;
        failures++;
        $display("FAIL watchdog: got no end of stimulus, expected end within 20000 cycles");
      end
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
